// File: rtl/audio_pkg.sv
// audio_pkg: shared state type and defaults for the PDM record/playback path.
package audio_pkg;
    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;
    localparam int WORD_W = 16;
    localparam int CLK_DIV_DEF = 32;
    localparam int ADDR_W_DEF = 17;
endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: free-running PDM mic clock divider with sample and bit strobes.
module pdm_clk_gen #(
    parameter int CLK_DIV = 32
) (
    input  logic clk,
    input  logic rst_n,
    output logic mic_clk,
    output logic sample_stb,
    output logic bit_tick
);
    localparam int DW = $clog2(CLK_DIV);
    logic [DW-1:0] div;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else div <= (div == DW'(CLK_DIV - 1)) ? '0 : div + DW'(1);
    end
    assign mic_clk = div >= DW'(CLK_DIV / 2);
    assign sample_stb = div == DW'(CLK_DIV / 2 - 1);
    assign bit_tick = div == DW'(CLK_DIV - 1);
endmodule

// File: rtl/audio_rec_ctrl.sv
// audio_rec_ctrl: records PDM mic bits into 16-bit BRAM words and replays them to the PWM amp.
module audio_rec_ctrl import audio_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop_req,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   rec_len,
    output logic              mic_clk,
    output logic              mic_lrsel,
    input  logic              mic_data,
    output logic              pwm_out,
    output logic              amp_sd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);
    localparam int BW = $clog2(WORD_W);
    state_t state, nxt;
    logic stb, tick, fin;
    logic [BW-1:0] bit_cnt;
    logic [WORD_W-1:0] sh, pre;
    logic [ADDR_W:0] wr_ptr, rd_cnt;
    logic [1:0] fill, pf;
    logic full, ready, last_bit;

    pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
        .clk(clk), .rst_n(rst_n), .mic_clk(mic_clk), .sample_stb(stb), .bit_tick(tick)
    );

    assign busy = state != IDLE;
    assign amp_sd = busy;
    assign mic_lrsel = 1'b0;
    assign full = mem_we && &mem_addr;
    assign ready = fill == 2'd3;
    assign last_bit = bit_cnt == BW'(WORD_W - 1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rec_req ? RECORD : play_req ? PLAY : IDLE;
            RECORD:  nxt = (stop_req || full) ? IDLE : RECORD;
            PLAY:    nxt = (stop_req || rec_len == '0 || (tick && ready && fin)) ? IDLE : PLAY;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done <= 1'b0;
            mem_we <= 1'b0;
            pwm_out <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            rec_len <= '0;
            sh <= '0;
            pre <= '0;
            wr_ptr <= '0;
            rd_cnt <= '0;
            bit_cnt <= '0;
            fill <= '0;
            pf <= '0;
            fin <= 1'b0;
        end else begin
            state <= nxt;
            done <= busy && nxt == IDLE;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    wr_ptr <= '0;
                    rd_cnt <= '0;
                    fill <= '0;
                    pf <= '0;
                    fin <= 1'b0;
                    if (nxt == PLAY && rec_len != '0) mem_addr <= '0;
                end
                RECORD: begin
                    if (stb) begin
                        sh <= {mic_data, sh[WORD_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        pwm_out <= mic_data;
                    end
                    // a stop on the strobe that completes a word drops that word
                    if (stb && last_bit && nxt == RECORD) begin
                        mem_we <= 1'b1;
                        mem_wdata <= {mic_data, sh[WORD_W-1:1]};
                        mem_addr <= wr_ptr[ADDR_W-1:0];
                    end
                    if (mem_we) wr_ptr <= wr_ptr + 1'b1;
                    if (nxt == IDLE) rec_len <= wr_ptr + (ADDR_W+1)'(mem_we);
                end
                PLAY: begin
                    fill <= ready ? fill : fill + 1'b1;
                    pf <= {pf[0], 1'b0};
                    if (nxt == PLAY && (fill == 2'd0 || (tick && ready && last_bit))) mem_addr <= mem_addr + 1'b1;
                    if (fill == 2'd1) sh <= mem_rdata;
                    if (fill == 2'd2 || pf[1]) pre <= mem_rdata;
                    if (tick && ready) begin
                        pwm_out <= sh[0];
                        sh <= last_bit ? pre : sh >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            rd_cnt <= rd_cnt + 1'b1;
                            fin <= (rd_cnt + 1'b1) == rec_len;
                            pf <= 2'b01;
                        end
                    end
                end
                default: ;
            endcase
            if (nxt == IDLE) pwm_out <= 1'b0;
        end
    end
endmodule

// File: doc/audio_rec_ctrl.md
# audio_rec_ctrl

Record/playback controller for the on-board PDM microphone and mono PWM amplifier path. It generates the microphone clock from the 100 MHz system clock and captures 1-bit PDM samples. It packs them into 16-bit words written to an external single-port block RAM, then replays a recording by streaming the stored bits back to the amplifier at the same rate. It sits between the debounced push-button logic and the audio pins and BRAM.

## Interface
- CLK_DIV, 32: system clocks per mic clock period; even, ≥ 8 (100 MHz / 32 = 3.125 MHz).
- ADDR_W, 17: BRAM word-address width; capacity 2^ADDR_W 16-bit words.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- rec_req  in  1  single-cycle pulse: start recording.
- play_req  in  1  single-cycle pulse: start playback.
- stop_req  in  1  single-cycle pulse: end the current record or playback.
- busy  out  1  high in RECORD or PLAY.
- done  out  1  one-cycle pulse on every return to IDLE from RECORD or PLAY.
- rec_len  out  ADDR_W+1  full words in the last completed recording.
- mic_clk  out  1  PDM microphone clock.
- mic_lrsel  out  1  constant 0; mic data on the rising edge.
- mic_data  in  1  PDM data from the microphone.
- pwm_out  out  1  amplifier PWM input.
- amp_sd  out  1  amplifier enable; 1 = on.
- mem_addr  out  ADDR_W  BRAM word address.
- mem_we  out  1  BRAM write strobe.
- mem_wdata  out  16  BRAM write data.
- mem_rdata  in  16  BRAM read data, valid one cycle after mem_addr is presented.

## Operation
- Free-running divider `div` runs 0..CLK_DIV-1 in all states.
  - mic_clk = (div ≥ CLK_DIV/2), so it is 0 for the first half-period and 1 for the second.
  - A sample strobe fires when div == CLK_DIV/2-1, the last cycle before the rising edge. A bit tick fires when div == CLK_DIV-1.
- FSM states: IDLE, RECORD, PLAY.
- IDLE
  - rec_req → RECORD. play_req → PLAY.
  - If both arrive in the same cycle, rec_req wins.
  - stop_req is ignored.
- RECORD
  - On entry, wr_ptr and bit_cnt are cleared.
  - On each sample strobe, mic_data is shifted into a 16-bit word LSB-first and registered to pwm_out (live monitor).
  - On the 16th bit: mem_we=1 for exactly one cycle, mem_addr=wr_ptr, mem_wdata=the packed word; then wr_ptr increments.
  - Exit to IDLE when the write to address 2^ADDR_W-1 completes (memory full) or on stop_req.
  - A partial word at stop is discarded. rec_len = words written.
- PLAY
  - If rec_len == 0: go straight to IDLE with a done pulse and no memory access.
  - Otherwise:
    - On entry, read address 0, load the returned word into the output shift register, and issue a prefetch of address 1.
    - On each bit tick, pwm_out = current LSB and the register shifts right.
    - After the 16th bit, the prefetched word is loaded and the next prefetch is issued.
    - Exit after the last bit of word rec_len-1, or on stop_req.
- rec_req and play_req while busy are ignored. A stop_req coincident with a mem_we cycle still commits that write.
- amp_sd = 1 in RECORD and PLAY, 0 in IDLE. pwm_out = 0 in IDLE.
- Counters wrap nowhere: wr_ptr saturates by leaving RECORD, and the divider wraps modulo CLK_DIV.

## Timing
- Reset values:
  - state IDLE; div, busy, done, mem_we, pwm_out, amp_sd, mic_clk = 0.
  - mem_addr, mem_wdata, rec_len = 0; mic_lrsel = 0 always.
- Reset mid-operation aborts immediately. rec_len returns to 0, so the previous recording is lost.
- busy rises the cycle after the accepted request and falls in the same cycle done pulses.
- Record latency: mem_we asserts one clock after the strobe that captured bit 15.
- Play latency: first bit reaches pwm_out at the first bit tick that occurs at least 3 cycles after entering PLAY.
- Bit period is exactly CLK_DIV cycles in both directions.
- mem_addr holds its last value when idle; mem_we is never high outside RECORD.

## Structure
- Shared package audio_pkg holds:
  - the state enum (IDLE/RECORD/PLAY);
  - WORD_W = 16;
  - default CLK_DIV and ADDR_W.
- One natural sub-module: pdm_clk_gen, containing the divider, mic_clk, and the sample_stb/bit_tick outputs. It is reusable by other mic-path blocks.
- FSM, pack/unpack shift registers and the BRAM interface stay in audio_rec_ctrl.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-RECORD.
  - Required: all outputs at reset values within the same cycle; busy=0; rec_len=0.
- Record pack:
  - Setup: ADDR_W=4; mic_data driven to the pattern 0xA5C3 LSB-first.
  - Stimulus: rec_req, then stop_req after 40 strobes.
  - Required: two writes of 0xA5C3 to addresses 0 and 1; partial word dropped; rec_len=2; one done pulse.
- Full memory:
  - Setup: ADDR_W=4.
  - Stimulus: record with no stop_req.
  - Required: exactly 16 writes to addresses 0..15; auto-return to IDLE; rec_len=16; mem_we never asserted again.
- Playback:
  - Setup: BRAM model preloaded with 0x0001, 0x8000; rec_len=2.
  - Stimulus: play_req.
  - Required: pwm_out sequence 1,0×15,0×15,1, each bit held 32 cycles; done after 32 bits; amp_sd high only during PLAY.
- Empty play:
  - Stimulus: play_req after reset.
  - Required: done pulse, no mem_addr change, busy high for at most 1 cycle.
- Collisions:
  - Stimulus: rec_req and play_req in the same cycle.
  - Required: RECORD entered.
  - Stimulus: play_req during RECORD.
  - Required: ignored.
  - Stimulus: stop_req in the mem_we cycle.
  - Required: that write is committed.
